vjtag_uart_fifo: RTL
====================

Name: vjtag_uart_fifo

Overview:
- Application-side endpoint of the VirtualJTAG byte link, in the m_clock domain.
- Consumes the link's receive events (recv_init/recv/recv_data) into an RX FIFO and presents them as a valid/ready byte stream to user logic.
- Buffers user TX bytes in a TX FIFO and answers each send_ready request by loading the next byte via send/send_data.
- Sits directly between the link module and the application.

Parameters:
- RX_DEPTH_LOG2, 4, log2 of RX FIFO depth (16 bytes).
- TX_DEPTH_LOG2, 4, log2 of TX FIFO depth (16 bytes).
- FILL_BYTE, 8'h00, byte returned to host when TX FIFO is empty.

Ports:
- m_clock  in  1  the only clock.
- p_reset_n  in  1  asynchronous, active-low reset.
- recv_init  in  1  one-cycle pulse: host started a receive session.
- recv  in  1  one-cycle pulse: recv_data holds a new byte.
- recv_data  in  8  received byte; valid when recv=1.
- send_init  in  1  one-cycle pulse: host started a send session.
- send_ready  in  1  one-cycle pulse: link wants the next byte.
- send  out  1  one-cycle load strobe to the link.
- send_data  out  8  byte loaded when send=1.
- rx_valid  out  1  RX FIFO not empty.
- rx_ready  in  1  user pops the RX head when rx_valid&rx_ready.
- rx_data  out  8  RX FIFO head (show-ahead).
- tx_valid  in  1  user push request.
- tx_ready  out  1  TX FIFO not full.
- tx_data  in  8  byte pushed when tx_valid&tx_ready.
- rx_count  out  RX_DEPTH_LOG2+1  RX occupancy.
- tx_count  out  TX_DEPTH_LOG2+1  TX occupancy.
- rx_overflow  out  1  sticky: a received byte was dropped.
- tx_underrun  out  1  sticky: FILL_BYTE was sent because the TX FIFO was empty.

Behaviour:
- Reset (async on p_reset_n low):
  - Both FIFOs empty; counts 0.
  - send=0, send_data=8'h00, rx_valid=0, tx_ready=1.
  - rx_overflow=0, tx_underrun=0; FSM in IDLE.
  - A reset mid-operation discards all buffered data; no send pulse is issued after reset.
- RX path:
  - recv=1 and RX not full: write recv_data at the same edge; rx_valid rises the next cycle.
  - recv=1 and RX full: drop the byte, set rx_overflow.
  - Pop on rx_valid&rx_ready. A push and pop in the same cycle are both honoured, including when full (the pop frees the slot, the byte is accepted).
  - recv_init clears rx_overflow and does not flush data. If recv_init and an overflow occur in the same cycle, the flag is set.
- TX path:
  - Push on tx_valid&tx_ready. Same-cycle push and pop are both honoured.
  - send_init clears tx_underrun and does not flush data.
- Send FSM, two states:
  - IDLE: on send_ready, go to LOAD.
  - LOAD (exactly one cycle):
    - If TX is non-empty, pop the head: send_data = head, send=1.
    - Else send_data = FILL_BYTE, send=1, set tx_underrun.
    - Return to IDLE.
  - send is registered, asserted exactly 1 cycle after send_ready, and always pulses for exactly 1 cycle.
  - A byte pushed in the send_ready cycle is visible in LOAD and is the byte sent.
  - send_ready arriving while in LOAD is ignored. The link guarantees at least 8 tck between requests, so this cannot occur legitimately.
- Pointers wrap modulo depth; occupancy is tracked with an extra wrap bit. Counts saturate naturally at 2^DEPTH_LOG2.

Optional Feature:
- Macro VJTAG_UART_FIFO_STATUS_EN.
- Defined: the first LOAD after send_init sends a status byte instead of FIFO data and does not pop the FIFO:
  - bit7 = rx_overflow, bit6 = tx_underrun, bits5:0 = tx_count saturated at 63.
  - This lets the host learn how many valid bytes follow.
  - The status byte reflects the flag values before send_init clears them, captured in the send_init cycle.
  - Subsequent LOADs behave normally.
- Undefined: no status byte; every LOAD follows the normal FIFO/FILL rule.

Decomposition:
- Package vjtag_uart_pkg:
  - FSM state type (IDLE, LOAD).
  - Default FILL_BYTE constant.
  - Status-byte bit positions (STAT_OVF=7, STAT_UDR=6, STAT_CNT_MSB=5).
- Sub-module sync_byte_fifo:
  - Parameter DEPTH_LOG2.
  - Show-ahead read, push/pop/full/empty/count.
  - Instantiated once each for RX and TX.

Test Plan:
- Reset then recv pulses carrying 8'h41, 8'h42, 8'h43 with rx_ready=0 -> rx_count=3, rx_data=8'h41; after three pops rx_valid=0.
- 17 recv pulses, no pops -> rx_count=16, rx_overflow=1, byte 17 lost; recv_init -> rx_overflow=0, rx_count stays 16.
- Push 8'hA5, 8'h5A; then two send_ready pulses -> send pulses 1 cycle after each with send_data 8'hA5 then 8'h5A; tx_count=0.
- TX empty, send_ready -> send=1 with 8'h00, tx_underrun=1; send_init -> tx_underrun=0.
- With STATUS_EN, rx_overflow=1, 3 bytes queued, send_init, send_ready -> send_data=8'h83, tx_count stays 3; next send_ready returns the first queued byte.
- Push in the send_ready cycle to an empty TX (8'h77), plus a p_reset_n pulse while 5 bytes are queued -> 8'h77 is sent with no underrun; after reset both counts=0, send=0.

Source files
------------

// File: rtl/vjtag_uart_pkg.sv
// -----------------------------------------------------------------------------
// vjtag_uart_pkg
// Shared definitions for the VirtualJTAG UART endpoint (vjtag_uart_fifo):
//   - send FSM state encoding
//   - default fill byte returned to the host when the TX FIFO is empty
//   - bit positions inside the optional status byte
// No ports (package).
// -----------------------------------------------------------------------------
package vjtag_uart_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } send_state_e;

  localparam logic [7:0] FILL_BYTE_DEFAULT = 8'h00;

  // Status byte layout: {overflow, underrun, tx occupancy saturated to 6 bits}
  localparam int STAT_OVF     = 7;
  localparam int STAT_UDR     = 6;
  localparam int STAT_CNT_MSB = 5;

endpackage : vjtag_uart_pkg

// File: rtl/vjtag_uart_fifo_sync_byte_fifo.sv
// -----------------------------------------------------------------------------
// sync_byte_fifo
// Single-clock byte FIFO with show-ahead read (rdata is always the head entry).
// Occupancy is tracked with pointers one bit wider than the address, so full
// and empty are distinguished by the wrap bit and count saturates naturally at
// 2**DEPTH_LOG2.
//
// Ports:
//   m_clock    in   clock
//   p_reset_n  in   asynchronous active-low reset (clears pointers only)
//   push       in   write wdata; accepted when not full, or when full and a
//                   pop happens in the same cycle
//   wdata      in   byte to write
//   pop        in   discard head entry; ignored when empty
//   rdata      out  head entry (undefined content while empty)
//   full       out  FIFO holds 2**DEPTH_LOG2 entries
//   empty      out  FIFO holds no entries
//   count      out  occupancy, DEPTH_LOG2+1 bits
// -----------------------------------------------------------------------------
module sync_byte_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  m_clock,
  input  logic                  p_reset_n,
  input  logic                  push,
  input  logic [7:0]            wdata,
  input  logic                  pop,
  output logic [7:0]            rdata,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  logic [7:0]          mem [DEPTH];
  logic [DEPTH_LOG2:0] wptr;
  logic [DEPTH_LOG2:0] rptr;
  logic                do_push;
  logic                do_pop;

  assign empty = (wptr == rptr);
  assign full  = (wptr[DEPTH_LOG2] != rptr[DEPTH_LOG2]) &&
                 (wptr[DEPTH_LOG2-1:0] == rptr[DEPTH_LOG2-1:0]);
  assign count = wptr - rptr;

  // A pop frees the slot the concurrent push needs, so a full FIFO still
  // accepts a write when it is also being read.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign rdata = mem[rptr[DEPTH_LOG2-1:0]];

  always_ff @(posedge m_clock or negedge p_reset_n) begin
    if (!p_reset_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // Storage is data only; stale contents after reset are never observable
  // because the pointers say empty.
  always_ff @(posedge m_clock) begin
    if (do_push) mem[wptr[DEPTH_LOG2-1:0]] <= wdata;
  end

endmodule : sync_byte_fifo

// File: rtl/vjtag_uart_fifo.sv
// -----------------------------------------------------------------------------
// vjtag_uart_fifo
// Application-side endpoint of the VirtualJTAG byte link (m_clock domain).
// Received link bytes are queued in an RX FIFO and offered to the user as a
// valid/ready stream; user bytes are queued in a TX FIFO and handed to the
// link one per send_ready request through a two-state send FSM.
//
// Optional build macro: VJTAG_UART_FIFO_STATUS_EN
//   When defined, the first LOAD after send_init returns a status byte
//   {rx_overflow, tx_underrun, tx_count sat. 63} captured in the send_init
//   cycle, without popping the TX FIFO. Undefined: every LOAD sends FIFO data
//   or FILL_BYTE.
//
// Ports:
//   m_clock      in   clock
//   p_reset_n    in   asynchronous active-low reset
//   recv_init    in   host started a receive session; clears rx_overflow
//   recv         in   recv_data holds a new byte
//   recv_data    in   received byte
//   send_init    in   host started a send session; clears tx_underrun
//   send_ready   in   link requests the next byte
//   send         out  one-cycle load strobe, 1 cycle after send_ready
//   send_data    out  byte loaded when send=1 (holds last byte otherwise)
//   rx_valid     out  RX FIFO not empty
//   rx_ready     in   user pops RX head on rx_valid&rx_ready
//   rx_data      out  RX head (show-ahead)
//   tx_valid     in   user push request
//   tx_ready     out  TX FIFO not full
//   tx_data      in   byte pushed on tx_valid&tx_ready
//   rx_count     out  RX occupancy
//   tx_count     out  TX occupancy
//   rx_overflow  out  sticky: received byte dropped on full RX FIFO
//   tx_underrun  out  sticky: FILL_BYTE sent because TX FIFO was empty
// -----------------------------------------------------------------------------
module vjtag_uart_fifo
  import vjtag_uart_pkg::*;
#(
  parameter int         RX_DEPTH_LOG2 = 4,
  parameter int         TX_DEPTH_LOG2 = 4,
  parameter logic [7:0] FILL_BYTE     = FILL_BYTE_DEFAULT
) (
  input  logic                     m_clock,
  input  logic                     p_reset_n,
  input  logic                     recv_init,
  input  logic                     recv,
  input  logic [7:0]               recv_data,
  input  logic                     send_init,
  input  logic                     send_ready,
  output logic                     send,
  output logic [7:0]               send_data,
  output logic                     rx_valid,
  input  logic                     rx_ready,
  output logic [7:0]               rx_data,
  input  logic                     tx_valid,
  output logic                     tx_ready,
  input  logic [7:0]               tx_data,
  output logic [RX_DEPTH_LOG2:0]   rx_count,
  output logic [TX_DEPTH_LOG2:0]   tx_count,
  output logic                     rx_overflow,
  output logic                     tx_underrun
);

  logic        rx_full;
  logic        rx_empty;
  logic        rx_pop;
  logic        tx_full;
  logic        tx_empty;
  logic        tx_push;
  logic        tx_pop;
  logic [7:0]  tx_head;

  send_state_e state;
  send_state_e state_nxt;
  logic [7:0]  send_data_q;
  logic [7:0]  load_byte;
  logic        underrun_set;

  // ---------------------------------------------------------------------------
  // RX path: link -> FIFO -> user
  // ---------------------------------------------------------------------------
  assign rx_valid = ~rx_empty;
  assign rx_pop   = rx_valid & rx_ready;

  sync_byte_fifo #(
    .DEPTH_LOG2 (RX_DEPTH_LOG2)
  ) u_rx_fifo (
    .m_clock   (m_clock),
    .p_reset_n (p_reset_n),
    .push      (recv),
    .wdata     (recv_data),
    .pop       (rx_pop),
    .rdata     (rx_data),
    .full      (rx_full),
    .empty     (rx_empty),
    .count     (rx_count)
  );

  // A byte is only lost when the FIFO is full and nothing leaves it this
  // cycle. Setting wins over the recv_init clear so no drop goes unreported.
  always_ff @(posedge m_clock or negedge p_reset_n) begin
    if (!p_reset_n) begin
      rx_overflow <= 1'b0;
    end else if (recv & rx_full & ~rx_pop) begin
      rx_overflow <= 1'b1;
    end else if (recv_init) begin
      rx_overflow <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // TX path: user -> FIFO -> link
  // ---------------------------------------------------------------------------
  assign tx_ready = ~tx_full;
  assign tx_push  = tx_valid & tx_ready;

  sync_byte_fifo #(
    .DEPTH_LOG2 (TX_DEPTH_LOG2)
  ) u_tx_fifo (
    .m_clock   (m_clock),
    .p_reset_n (p_reset_n),
    .push      (tx_push),
    .wdata     (tx_data),
    .pop       (tx_pop),
    .rdata     (tx_head),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count)
  );

  always_ff @(posedge m_clock or negedge p_reset_n) begin
    if (!p_reset_n) begin
      tx_underrun <= 1'b0;
    end else if (underrun_set) begin
      tx_underrun <= 1'b1;
    end else if (send_init) begin
      tx_underrun <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional status byte, armed by send_init and consumed by the next LOAD
  // ---------------------------------------------------------------------------
`ifdef VJTAG_UART_FIFO_STATUS_EN
  logic       stat_pend;
  logic       stat_take;
  logic [7:0] stat_byte;

  function automatic logic [STAT_CNT_MSB:0] sat_cnt(input logic [TX_DEPTH_LOG2:0] c);
    logic [31:0] w;
    w = 32'(c);
    if (w > 32'd63) return '1;
    return w[STAT_CNT_MSB:0];
  endfunction

  // send_init re-arms even if it coincides with a LOAD taking the old byte.
  always_ff @(posedge m_clock or negedge p_reset_n) begin
    if (!p_reset_n) begin
      stat_pend <= 1'b0;
    end else if (send_init) begin
      stat_pend <= 1'b1;
    end else if (stat_take) begin
      stat_pend <= 1'b0;
    end
  end

  // Captures flag values as they stand before send_init clears them.
  always_ff @(posedge m_clock) begin
    if (send_init) begin
      stat_byte[STAT_OVF]       <= rx_overflow;
      stat_byte[STAT_UDR]       <= tx_underrun;
      stat_byte[STAT_CNT_MSB:0] <= sat_cnt(tx_count);
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Send FSM: IDLE waits for send_ready, LOAD lasts one cycle and drives send.
  // send is the LOAD state itself, so it is a flop output one cycle after
  // send_ready. send_data is chosen during LOAD so a byte pushed in the
  // send_ready cycle is already at the TX head and gets sent.
  // ---------------------------------------------------------------------------
  always_ff @(posedge m_clock or negedge p_reset_n) begin
    if (!p_reset_n) begin
      state       <= IDLE;
      send_data_q <= 8'h00;
    end else begin
      state       <= state_nxt;
      send_data_q <= load_byte;
    end
  end

  always_comb begin
    state_nxt    = state;
    load_byte    = send_data_q;
    tx_pop       = 1'b0;
    underrun_set = 1'b0;
`ifdef VJTAG_UART_FIFO_STATUS_EN
    stat_take    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (send_ready) state_nxt = LOAD;
      end
      LOAD: begin
        // send_ready here is ignored; the link spaces requests far apart.
        state_nxt = IDLE;
`ifdef VJTAG_UART_FIFO_STATUS_EN
        if (stat_pend) begin
          load_byte = stat_byte;
          stat_take = 1'b1;
        end else
`endif
        if (!tx_empty) begin
          load_byte = tx_head;
          tx_pop    = 1'b1;
        end else begin
          load_byte    = FILL_BYTE;
          underrun_set = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign send      = (state == LOAD);
  assign send_data = load_byte;

endmodule : vjtag_uart_fifo
